// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and default sizes for the dual-port memory
package mem_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } mem_state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/mem_clear_ctrl.sv
// rtl/mem_clear_ctrl.sv - post-reset walk that zeroes every word before requests are accepted
module mem_clear_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  mem_state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      clr_addr <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_addr <= clr_addr + 1'b1;
          // ready tracks the state it is entering so it rises on the last clear edge
          if (clr_addr == {ADDR_W{1'b1}}) begin
            state <= ST_READY;
            ready <= 1'b1;
          end else begin
            ready <= 1'b0;
          end
        end
        default: begin
          state <= ST_READY;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign clr_en = (state == ST_INIT) && !rst;

endmodule

// File: rtl/dual_port_memory.sv
// rtl/dual_port_memory.sv - byte-writable 1R1W memory with clear-on-reset and write-first bypass
module dual_port_memory
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                ready
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] rd_merged;

  mem_clear_ctrl #(.ADDR_W(ADDR_W)) u_clear (
    .clk      (clk),
    .rst      (rst),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // Single write port: the clear walk owns it until ready, then user writes
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (ready && !rst && wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_merged = mem[rd_addr];
    for (int i = 0; i < NB; i++) begin
      if (wr_en && (wr_addr == rd_addr) && wr_be[i]) rd_merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (ready && rd_en) begin
      rd_valid <= 1'b1;
      rd_data  <= rd_merged;
    end else begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end
  end

endmodule

// File: tb/tb_dual_port_memory.sv
// tb/tb_dual_port_memory.sv - directed bench with a reference model checked every cycle
module tb_dual_port_memory;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [1:0]    wr_be = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          ready;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  dual_port_memory #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  // Reference model: counts reset-free edges, zeroes the whole array once clearing completes
  logic [DW-1:0] m_mem [DEPTH];
  int            m_cnt = 0;
  logic          m_ready = 1'b0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clk) begin
    logic [DW-1:0] merged;
    if (rst) begin
      m_cnt   = 0;
      m_ready = 1'b0;
      m_valid = 1'b0;
      m_data  = '0;
    end else begin
      if (m_ready && rd_en) begin
        merged = m_mem[rd_addr];
        if (wr_en && wr_addr == rd_addr) begin
          if (wr_be[0]) merged[7:0]  = wr_data[7:0];
          if (wr_be[1]) merged[15:8] = wr_data[15:8];
        end
        m_valid = 1'b1;
        m_data  = merged;
      end else begin
        m_valid = 1'b0;
        m_data  = '0;
      end
      if (m_ready && wr_en) begin
        if (wr_be[0]) m_mem[wr_addr][7:0]  = wr_data[7:0];
        if (wr_be[1]) m_mem[wr_addr][15:8] = wr_data[15:8];
      end
      if (!m_ready) begin
        m_cnt++;
        if (m_cnt == DEPTH) begin
          m_ready = 1'b1;
          for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("model_ready", {31'd0, ready}, {31'd0, m_ready});
      check("model_rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
      check("model_rd_data", {16'd0, rd_data}, {16'd0, m_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                    input logic [1:0] be, input logic re, input logic [AW-1:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; wr_be = 2'b00;
  endtask

  task automatic read_expect(input string name, input logic [AW-1:0] ra, input logic [DW-1:0] exp);
    op(1'b0, '0, '0, 2'b00, 1'b1, ra);
    check({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check(name, {16'd0, rd_data}, {16'd0, exp});
  endtask

  // Counts DEPTH edges after release, optionally driving ignored requests late in the walk
  task automatic init_walk(input string name, input bit poke);
    for (int k = 1; k <= DEPTH; k++) begin
      if (poke && k >= 150) begin
        wr_en = 1'b1; wr_addr = 8'h05; wr_data = 16'hFFFF; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 8'h05;
      end
      tick();
      if (poke && k >= 151) check({name, "_init_rd_valid"}, {31'd0, rd_valid}, 32'd0);
      if (k == DEPTH - 1) check({name, "_ready_255"}, {31'd0, ready}, 32'd0);
      if (k == DEPTH) check({name, "_ready_256"}, {31'd0, ready}, 32'd1);
    end
    wr_en = 1'b0; rd_en = 1'b0; wr_be = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    checking = 1'b1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("reset_rd_data", {16'd0, rd_data}, 32'd0);
    tick();
    rst = 1'b0;
    init_walk("first", 1'b0);
    read_expect("rd_ff", 8'hFF, 16'h0000);

    op(1'b1, 8'h10, 16'hABCD, 2'b11, 1'b0, '0);
    read_expect("rd_10", 8'h10, 16'hABCD);

    op(1'b1, 8'h20, 16'hABCD, 2'b11, 1'b0, '0);
    op(1'b1, 8'h20, 16'h1234, 2'b01, 1'b0, '0);
    read_expect("rd_20_be01", 8'h20, 16'hAB34);
    op(1'b1, 8'h20, 16'h9999, 2'b00, 1'b0, '0);
    read_expect("rd_20_be00", 8'h20, 16'hAB34);

    op(1'b1, 8'h30, 16'h5555, 2'b11, 1'b1, 8'h30);
    check("bypass_valid", {31'd0, rd_valid}, 32'd1);
    check("bypass_30", {16'd0, rd_data}, 32'h5555);
    op(1'b1, 8'h31, 16'h6677, 2'b10, 1'b1, 8'h31);
    check("bypass_31_hi", {16'd0, rd_data}, 32'h6600);

    op(1'b1, 8'h40, 16'h1111, 2'b11, 1'b1, 8'h10);
    check("diff_addr_rd", {16'd0, rd_data}, 32'hABCD);
    read_expect("diff_addr_wr", 8'h40, 16'h1111);

    rd_en = 1'b1; rd_addr = 8'h10;
    tick();
    check("b2b_0", {16'd0, rd_data}, 32'hABCD);
    rd_addr = 8'h20;
    tick();
    check("b2b_1", {16'd0, rd_data}, 32'hAB34);
    rd_addr = 8'h30;
    tick();
    check("b2b_2", {16'd0, rd_data}, 32'h5555);
    check("b2b_2_valid", {31'd0, rd_valid}, 32'd1);
    rd_en = 1'b0;
    tick();
    check("idle_rd_data", {16'd0, rd_data}, 32'h0000);

    op(1'b1, 8'h05, 16'h7777, 2'b11, 1'b0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      rd_en = 1'b1; rd_addr = 8'h10;
      tick();
      check("init_rd_ignored", {31'd0, rd_valid}, 32'd0);
    end
    rd_en = 1'b0;
    rst = 1'b1;
    rd_en = 1'b1; rd_addr = 8'h10;
    tick();
    check("midinit_rst_valid", {31'd0, rd_valid}, 32'd0);
    rd_en = 1'b0;
    rst = 1'b0;
    init_walk("restart", 1'b1);
    read_expect("rd_10_cleared", 8'h10, 16'h0000);
    read_expect("rd_05_cleared", 8'h05, 16'h0000);

    rd_en = 1'b1; rd_addr = 8'h40;
    op(1'b1, 8'h40, 16'h2222, 2'b11, 1'b1, 8'h40);
    rst = 1'b1;
    tick();
    check("rst_discards_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_discards_data", {16'd0, rd_data}, 32'h0000);
    rst = 1'b0;
    tick();

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
